// File: rtl/wb_led_sequencer.sv
// ---------------------------------------------------------------------------
// wb_led_sequencer
//   Wishbone-slave LED pattern sequencer. Firmware loads a pattern table, a
//   dwell time and an output-enable mask, then sets EN. The sequencer steps
//   through PAT[0..last] onto led_o, holding each entry for DWELL+1 cycles.
//   It either wraps continuously or, in one-shot mode, stops on the last
//   entry and raises DONE (and irq_o when IRQ_EN is set).
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i   Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]         byte selects
//   wbs_adr_i[31:0]        address, decoded on adr[31:8] == BASE_ADDR[31:8]
//   wbs_dat_i[31:0]        write data
//   wbs_ack_o              one-cycle acknowledge, one wait state
//   wbs_dat_o[31:0]        registered read data
//   led_o[NUM_LEDS-1:0]    LED drive
//   led_oeb_o[NUM_LEDS-1:0] active-low output enables (OEB register)
//   irq_o                  level interrupt, DONE & IRQ_EN registered
//
// Register map (byte offsets)
//   0x00 CTRL    [0]EN [1]ONESHOT [2]IRQ_EN [6:4]LAST
//   0x04 STATUS  [0]BUSY (ro) [1]DONE (w1c) [6:4]IDX (ro)
//   0x08 DWELL   [DWELL_W-1:0]
//   0x0C OEB     [NUM_LEDS-1:0]
//   0x20+4*i PAT[i] [NUM_LEDS-1:0], i < DEPTH
// ---------------------------------------------------------------------------
module wb_led_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_LEDS  = 8,
    parameter int          DEPTH     = 8,
    parameter int          DWELL_W   = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NUM_LEDS-1:0] led_o,
    output logic [NUM_LEDS-1:0] led_oeb_o,
    output logic                irq_o
);
    localparam int         IW      = $clog2(DEPTH);
    localparam logic [2:0] MAX_IDX = 3'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [3:0]  sel;
        logic [5:0]  word;
        logic [31:0] dat;
    } wb_req_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
        return m;
    endfunction

    // Register state
    logic                           en_q, oneshot_q, irq_en_q, done_q;
    logic [2:0]                     last_q;
    logic [DWELL_W-1:0]             dwell_q, cnt_q;
    logic [NUM_LEDS-1:0]            oeb_q, led_q;
    logic [DEPTH-1:0][NUM_LEDS-1:0] pat_q;
    logic [IW-1:0]                  idx_q;
    state_t                         state_q;
    logic                           ack_q, irq_q;
    logic [31:0]                    dat_q;

    // Access decode
    wb_req_t             req;
    logic                acc, hit;
    logic [31:0]         mask, rdata, ctrl_rd, status_rd;
    logic [6:0]          ctrl_new;
    logic [DWELL_W-1:0]  dwell_new;
    logic [NUM_LEDS-1:0] oeb_new, pat_new;
    logic [DEPTH-1:0]    pat_we;
    logic                wr_ctrl, wr_status, wr_dwell, wr_oeb;
    logic                en_rise, en_fall, done_clr;
    logic [IW-1:0]       last_eff;
    logic                unused_ok;

    // The access fires on the cycle before ack rises; that edge both raises
    // ack and commits the write, giving exactly one wait state.
    assign acc = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req = '{wr:   acc & hit & wbs_we_i,
                   rd:   acc & hit & ~wbs_we_i,
                   sel:  wbs_sel_i,
                   word: wbs_adr_i[7:2],
                   dat:  wbs_dat_i};

    assign mask = byte_mask(req.sel);

    assign wr_ctrl   = req.wr && (req.word == 6'd0);
    assign wr_status = req.wr && (req.word == 6'd1);
    assign wr_dwell  = req.wr && (req.word == 6'd2);
    assign wr_oeb    = req.wr && (req.word == 6'd3);

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_pat_dec
            assign pat_we[g] = req.wr && (req.word == 6'(8 + g));
        end
    endgenerate

    assign ctrl_rd   = {25'b0, last_q, 1'b0, irq_en_q, oneshot_q, en_q};
    assign status_rd = {25'b0, 3'(idx_q), 2'b0, done_q, state_q == S_RUN};

    // Byte-merged write values: unselected bytes keep their old contents.
    assign ctrl_new  = (ctrl_rd[6:0] & ~mask[6:0]) | (req.dat[6:0] & mask[6:0]);
    assign dwell_new = (dwell_q & ~mask[DWELL_W-1:0]) | (req.dat[DWELL_W-1:0] & mask[DWELL_W-1:0]);
    assign oeb_new   = (oeb_q & ~mask[NUM_LEDS-1:0]) | (req.dat[NUM_LEDS-1:0] & mask[NUM_LEDS-1:0]);
    assign pat_new   = req.dat[NUM_LEDS-1:0];

    // EN edges only exist when byte 0 is actually written.
    assign en_rise  = wr_ctrl & req.sel[0] & req.dat[0] & ~en_q;
    assign en_fall  = wr_ctrl & req.sel[0] & ~req.dat[0];
    assign done_clr = wr_status & req.sel[0] & req.dat[1];

    assign last_eff = (last_q > MAX_IDX) ? IW'(MAX_IDX) : IW'(last_q);

    always_comb begin
        rdata = '0;
        if (req.rd) begin
            case (req.word)
                6'd0:    rdata = ctrl_rd;
                6'd1:    rdata = status_rd;
                6'd2:    rdata = 32'(dwell_q);
                6'd3:    rdata = 32'(oeb_q);
                default: begin
                    for (int i = 0; i < DEPTH; i++)
                        if (req.word == 6'(8 + i)) rdata = 32'(pat_q[i]);
                end
            endcase
        end
    end

    // Pattern table; bytes merged per sel like every other register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pat_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (pat_we[i])
                    pat_q[i] <= (pat_q[i] & ~mask[NUM_LEDS-1:0]) | (pat_new & mask[NUM_LEDS-1:0]);
        end
    end

    // Bus interface, control registers and sequencer FSM.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            last_q    <= '0;
            done_q    <= 1'b0;
            dwell_q   <= '0;
            oeb_q     <= '1;
            cnt_q     <= '0;
            idx_q     <= '0;
            led_q     <= '0;
            irq_q     <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            ack_q <= acc;
            dat_q <= rdata;
            irq_q <= done_q & irq_en_q;

            if (wr_ctrl) begin
                en_q      <= ctrl_new[0];
                oneshot_q <= ctrl_new[1];
                irq_en_q  <= ctrl_new[2];
                last_q    <= ctrl_new[6:4];
            end
            if (wr_dwell) dwell_q <= dwell_new;
            if (wr_oeb)   oeb_q   <= oeb_new;
            if (done_clr) done_q  <= 1'b0;

            // Later assignments win: a DONE set on the same edge as a W1C
            // clear leaves DONE set.
            if (en_fall) begin
                state_q <= S_IDLE;
                led_q   <= '0;
            end else if (en_rise) begin
                state_q <= S_RUN;
                idx_q   <= '0;
                led_q   <= pat_q[0];
                cnt_q   <= dwell_q;
                done_q  <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else if (idx_q < last_eff) begin
                    idx_q <= idx_q + 1'b1;
                    led_q <= pat_q[idx_q + 1'b1];
                    cnt_q <= dwell_q;
                end else if (!oneshot_q) begin
                    idx_q <= '0;
                    led_q <= pat_q[0];
                    cnt_q <= dwell_q;
                end else begin
                    // Last entry stays on the pins in DONE.
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign led_o     = led_q;
    assign led_oeb_o = oeb_q;
    assign irq_o     = irq_q;

    // Word-aligned bus: byte address bits and the upper data/mask bits of
    // narrow registers carry no meaning.
    assign unused_ok = &{1'b0, wbs_adr_i[1:0], req.dat, mask, ctrl_new[3]};

endmodule

// File: tb/tb_wb_led_sequencer.sv
module tb_wb_led_sequencer;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] A_CTRL  = BASE + 32'h00;
    localparam logic [31:0] A_STAT  = BASE + 32'h04;
    localparam logic [31:0] A_DWELL = BASE + 32'h08;
    localparam logic [31:0] A_OEB   = BASE + 32'h0C;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        cyc  = 1'b0;
    logic        stb  = 1'b0;
    logic        we   = 1'b0;
    logic [3:0]  sel  = 4'h0;
    logic [31:0] adr  = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  led, oeb;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_led_sequencer #(
        .BASE_ADDR(BASE), .NUM_LEDS(8), .DEPTH(8), .DWELL_W(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .led_o(led), .led_oeb_o(oeb), .irq_o(irq)
    );

    // Reference model: playback computed from elapsed cycles since the
    // enabling write (n = 0 on the commit edge).
    logic [7:0] mpat [8];
    int md, ml, mos, mie;

    function automatic int eff_last();
        return ml % 8;
    endfunction

    function automatic logic [7:0] exp_led(input int n);
        int k, le;
        le = eff_last();
        k  = n / (md + 1);
        if (mos != 0) return mpat[(k > le) ? le : k];
        return mpat[k % (le + 1)];
    endfunction

    function automatic logic [31:0] exp_status(input int n);
        int k, le, idx;
        logic done;
        le   = eff_last();
        k    = n / (md + 1);
        done = (mos != 0) && (k > le);
        idx  = (mos != 0) ? ((k > le) ? le : k) : (k % (le + 1));
        return {25'b0, 3'(idx), 2'b0, done, ~done};
    endfunction

    function automatic logic exp_irq(input int n);
        return (mie != 0) && (mos != 0) && (n >= 1) && (((n - 1) / (md + 1)) > eff_last());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus access starting 1ns after an edge; returns 1ns after the ack
    // edge with the number of edges consumed.
    task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r, output int edges);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        edges = 0;
        while (edges < 8) begin
            @(posedge clk); #1;
            edges++;
            if (ack) break;
        end
        if (!ack) begin
            checks++; failures++;
            $display("FAIL wb_ack_timeout: got ack=0 expected ack=1 at %h", a);
        end
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int e;
        wb_acc(1'b1, a, d, 4'hF, r, e);
    endtask

    task automatic run_seq(input int d, input int l, input int os, input int ie,
                           input int ncyc, output int n);
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h2);
        for (int i = 0; i < 8; i++) wr(BASE + 32'(32 + 4 * i), {24'h0, mpat[i]});
        wr(A_DWELL, 32'(d));
        md = d; ml = l; mos = os; mie = ie;
        wr(A_CTRL, 32'((l << 4) | (ie << 2) | (os << 1) | 1));
        n = 0;
        chk("seq_led_start", led, exp_led(n));
        chk("seq_irq_start", irq, exp_irq(n));
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            n++;
            chk($sformatf("seq_led n=%0d", n), led, exp_led(n));
            chk($sformatf("seq_irq n=%0d", n), irq, exp_irq(n));
        end
    endtask

    task automatic status_chk(input string name, inout int n);
        logic [31:0] r;
        int e;
        wb_acc(1'b0, A_STAT, 32'h0, 4'hF, r, e);
        chk(name, r, exp_status(n + e - 1));
        n += e;
    endtask

    typedef struct {
        logic [31:0] wadr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] radr;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [13];

    initial begin
        logic [31:0] r;
        int e, n;

        vecs[0]  = '{A_DWELL, 32'h0000_0000, 4'hF, A_DWELL, 32'h0000_0000};
        vecs[1]  = '{A_DWELL, 32'hFFFF_FFFF, 4'h1, A_DWELL, 32'h0000_00FF};
        vecs[2]  = '{A_DWELL, 32'h1234_5678, 4'h2, A_DWELL, 32'h0000_56FF};
        vecs[3]  = '{A_DWELL, 32'hFFFF_FFFF, 4'hF, A_DWELL, 32'h0000_FFFF};
        vecs[4]  = '{A_OEB,   32'h0000_00A5, 4'hF, A_OEB,   32'h0000_00A5};
        vecs[5]  = '{A_OEB,   32'hFFFF_FF5A, 4'h1, A_OEB,   32'h0000_005A};
        vecs[6]  = '{BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, BASE + 32'h10, 32'h0};
        vecs[7]  = '{BASE + 32'h20, 32'h1234_56C3, 4'hF, BASE + 32'h20, 32'h0000_00C3};
        vecs[8]  = '{BASE + 32'h3C, 32'h0000_0081, 4'hF, BASE + 32'h3C, 32'h0000_0081};
        vecs[9]  = '{BASE + 32'h40, 32'h0000_0055, 4'hF, BASE + 32'h40, 32'h0};
        vecs[10] = '{A_CTRL,  32'h0000_00F6, 4'hF, A_CTRL,  32'h0000_0076};
        vecs[11] = '{A_CTRL,  32'h0000_0000, 4'hF, A_CTRL,  32'h0000_0000};
        vecs[12] = '{32'h3000_0108, 32'h0000_0000, 4'hF, A_DWELL, 32'h0000_FFFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", led, 8'h00);
        chk("rst_oeb", oeb, 8'hFF);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_dat", rdat, 32'h0);
        rst = 1'b0;
        wb_acc(1'b0, A_STAT, 32'h0, 4'hF, r, e);
        chk("rst_status", r, 32'h0);

        // Register access vectors
        for (int i = 0; i < 13; i++) begin
            wb_acc(1'b1, vecs[i].wadr, vecs[i].wdat, vecs[i].sel, r, e);
            wb_acc(1'b0, vecs[i].radr, 32'h0, 4'hF, r, e);
            chk($sformatf("reg_vec%0d", i), r, vecs[i].exp);
        end
        chk("oeb_pins", oeb, 8'h5A);

        // ack is one cycle wide
        wr(A_DWELL, 32'h0);
        @(posedge clk); #1;
        chk("ack_width", ack, 1'b0);

        // Continuous wrap, no restart on repeated EN=1, reset mid-run
        wr(A_OEB, 32'h0);
        chk("oeb_zero", oeb, 8'h00);
        mpat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq(4, 3, 0, 0, 45, n);
        status_chk("wrap_status", n);
        wb_acc(1'b1, A_CTRL, 32'h31, 4'hF, r, e);
        n += e;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            n++;
            chk("norestart_led", led, exp_led(n));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_led", led, 8'h00);
        chk("midrst_oeb", oeb, 8'hFF);
        chk("midrst_irq", irq, 1'b0);
        wb_acc(1'b0, A_STAT, 32'h0, 4'hF, r, e);
        chk("midrst_status", r, 32'h0);
        wb_acc(1'b0, A_DWELL, 32'h0, 4'hF, r, e);
        chk("midrst_dwell", r, 32'h0);

        // One-shot with interrupt, then W1C
        run_seq(4, 3, 1, 1, 25, n);
        wb_acc(1'b0, A_STAT, 32'h0, 4'hF, r, e);
        chk("oneshot_status", r, 32'h32);
        chk("oneshot_led", led, 8'h08);
        chk("oneshot_irq", irq, 1'b1);
        wr(A_STAT, 32'h2);
        @(posedge clk); #1;
        chk("w1c_irq", irq, 1'b0);
        chk("w1c_led_hold", led, 8'h08);
        wb_acc(1'b0, A_STAT, 32'h0, 4'hF, r, e);
        chk("w1c_status", r, 32'h30);

        // DWELL=0 with LAST=15 written (field clamps to entry 7)
        for (int i = 0; i < 8; i++) mpat[i] = 8'(1 << i);
        run_seq(0, 15, 0, 0, 20, n);
        status_chk("fast_status", n);

        // EN cleared mid-run at IDX=2, then re-enabled
        mpat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq(4, 3, 0, 0, 10, n);
        chk("idx2_led", led, 8'h04);
        wb_acc(1'b1, A_CTRL, 32'h0, 4'hF, r, e);
        chk("enclr_led", led, 8'h00);
        wb_acc(1'b0, A_STAT, 32'h0, 4'hF, r, e);
        chk("enclr_busy", r[0], 1'b0);
        wb_acc(1'b1, A_CTRL, 32'h31, 4'hF, r, e);
        n = 0;
        chk("reen_led", led, 8'h01);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            n++;
            chk("reen_step", led, exp_led(n));
        end

        // Randomized playback against the model
        for (int t = 0; t < 12; t++) begin
            int d, l, os, ie, nc;
            d  = $urandom_range(0, 4);
            l  = $urandom_range(0, 7);
            os = $urandom_range(0, 1);
            ie = $urandom_range(0, 1);
            for (int i = 0; i < 8; i++) mpat[i] = 8'($urandom);
            nc = (l + 1) * (d + 1) + $urandom_range(2, 30);
            run_seq(d, l, os, ie, nc, n);
            status_chk($sformatf("rand%0d_status", t), n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
